// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite responder backed by a word-addressed register file with byte-strobe writes,
// programmable response wait states and SLVERR for accesses outside the address window.
module axi_lite_mem_slave #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           MEM_DEPTH   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned           WAIT_CYCLES = 0
) (
  input  logic                    aclk,
  input  logic                    areset_n,
  // write address / data / response
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  // read address / data
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] WAIT_INIT =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_e;

  // Address window decode; the two low address bits never affect the word index.
  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] offs;
    offs = addr - BASE_ADDR;
    return (addr >= BASE_ADDR) && ((offs >> 2) < ADDR_WIDTH'(MEM_DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] addr);
    return IDX_W'((addr - BASE_ADDR) >> 2);
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  // ---------------------------------------------------------------- write path
  wstate_e               wstate_q, wstate_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic [CNT_W-1:0]      wcnt_q, wcnt_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;

  logic                  aw_hs_c, w_hs_c, commit_c, mem_we_c;
  logic [ADDR_WIDTH-1:0] waddr_c;
  logic [DATA_WIDTH-1:0] wdata_c;
  logic [STRB_W-1:0]     wstrb_c;
  logic [IDX_W-1:0]      widx_c;

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wcnt_q    <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      wstate_q  <= wstate_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      wcnt_q    <= wcnt_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Write FSM: AW and W are captured independently; the commit happens on the edge
  // where the second of the two arrives, using live bus values for that channel.
  always_comb begin
    wstate_d  = wstate_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    wcnt_d    = wcnt_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    commit_c  = 1'b0;
    aw_hs_c   = awvalid & awready_q;
    w_hs_c    = wvalid & wready_q;
    waddr_c   = aw_hs_c ? awaddr : awaddr_q;
    wdata_c   = w_hs_c ? wdata : wdata_q;
    wstrb_c   = w_hs_c ? wstrb : wstrb_q;

    unique case (wstate_q)
      W_IDLE: begin
        if (aw_hs_c) begin
          awaddr_d  = awaddr;
          aw_done_d = 1'b1;
        end
        if (w_hs_c) begin
          wdata_d  = wdata;
          wstrb_d  = wstrb;
          w_done_d = 1'b1;
        end
        if ((aw_done_q | aw_hs_c) & (w_done_q | w_hs_c)) begin
          commit_c  = 1'b1;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          bresp_d   = addr_in_range(waddr_c) ? RESP_OKAY : RESP_SLVERR;
          if (WAIT_CYCLES == 0) begin
            wstate_d = W_RESP;
            bvalid_d = 1'b1;
          end else begin
            wstate_d = W_WAIT;
            wcnt_d   = WAIT_INIT;
          end
        end else begin
          awready_d = ~(aw_done_q | aw_hs_c);
          wready_d  = ~(w_done_q | w_hs_c);
        end
      end
      W_WAIT: begin
        if (wcnt_q == '0) begin
          wstate_d = W_RESP;
          bvalid_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q - CNT_W'(1);
        end
      end
      W_RESP: begin
        if (bready) begin
          wstate_d  = W_IDLE;
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  assign mem_we_c = commit_c & addr_in_range(waddr_c);
  assign widx_c   = addr_idx(waddr_c);

  // Register file; unstrobed bytes keep their previous contents.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we_c) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (wstrb_c[b]) begin
          mem_q[widx_c][b*8 +: 8] <= wdata_c[b*8 +: 8];
        end
      end
    end
  end

  // ----------------------------------------------------------------- read path
  rstate_e               rstate_q, rstate_d;
  logic                  arready_q, arready_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [CNT_W-1:0]      rcnt_q, rcnt_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  logic                  ar_hs_c, rd_in_range_c;
  logic [ADDR_WIDTH-1:0] rsel_addr_c;
  logic [DATA_WIDTH-1:0] rd_word_c;

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      araddr_q  <= '0;
      rcnt_q    <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      rstate_q  <= rstate_d;
      arready_q <= arready_d;
      araddr_q  <= araddr_d;
      rcnt_q    <= rcnt_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // Memory is sampled with the pre-commit contents, so a same-edge write is not visible.
  always_comb begin
    rstate_d      = rstate_q;
    arready_d     = arready_q;
    araddr_d      = araddr_q;
    rcnt_d        = rcnt_q;
    rvalid_d      = rvalid_q;
    rdata_d       = rdata_q;
    rresp_d       = rresp_q;
    ar_hs_c       = arvalid & arready_q;
    rsel_addr_c   = (rstate_q == R_IDLE) ? araddr : araddr_q;
    rd_in_range_c = addr_in_range(rsel_addr_c);
    rd_word_c     = rd_in_range_c ? mem_q[addr_idx(rsel_addr_c)] : '0;

    unique case (rstate_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs_c) begin
          arready_d = 1'b0;
          araddr_d  = araddr;
          if (WAIT_CYCLES == 0) begin
            rstate_d = R_DATA;
            rvalid_d = 1'b1;
            rdata_d  = rd_word_c;
            rresp_d  = rd_in_range_c ? RESP_OKAY : RESP_SLVERR;
          end else begin
            rstate_d = R_WAIT;
            rcnt_d   = WAIT_INIT;
          end
        end
      end
      R_WAIT: begin
        if (rcnt_q == '0) begin
          rstate_d = R_DATA;
          rvalid_d = 1'b1;
          rdata_d  = rd_word_c;
          rresp_d  = rd_in_range_c ? RESP_OKAY : RESP_SLVERR;
        end else begin
          rcnt_d = rcnt_q - CNT_W'(1);
        end
      end
      R_DATA: begin
        if (rready) begin
          rstate_d  = R_IDLE;
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Drives two responders (WAIT_CYCLES 0 and 3) with identical traffic and checks each
// against an array-based memory model plus the expected per-instance response latency.
module tb_axi_lite_mem_slave;

  localparam int unsigned DEPTH = 16;

  logic        aclk = 1'b0;
  logic        areset_n;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;

  logic        awready_s [2];
  logic        wready_s  [2];
  logic        bvalid_s  [2];
  logic        arready_s [2];
  logic        rvalid_s  [2];
  logic [1:0]  bresp_s   [2];
  logic [1:0]  rresp_s   [2];
  logic [31:0] rdata_s   [2];

  always #5 aclk = ~aclk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    axi_lite_mem_slave #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .MEM_DEPTH  (DEPTH),
      .BASE_ADDR  (32'h0000_0000),
      .WAIT_CYCLES(g * 3)
    ) u_dut (
      .aclk    (aclk),
      .areset_n(areset_n),
      .awaddr  (awaddr),
      .awvalid (awvalid),
      .awready (awready_s[g]),
      .wdata   (wdata),
      .wstrb   (wstrb),
      .wvalid  (wvalid),
      .wready  (wready_s[g]),
      .bresp   (bresp_s[g]),
      .bvalid  (bvalid_s[g]),
      .bready  (bready),
      .araddr  (araddr),
      .arvalid (arvalid),
      .arready (arready_s[g]),
      .rdata   (rdata_s[g]),
      .rresp   (rresp_s[g]),
      .rvalid  (rvalid_s[g]),
      .rready  (rready)
    );
  end

  int n_checks = 0;
  int n_errors = 0;
  int n_wr = 0;
  int n_rd = 0;
  int b_cnt [2];
  int r_cnt [2];

  logic [31:0] mem_m [DEPTH];

  logic [1:0]  b_resp [2];
  int          b_lat  [2];
  logic [31:0] r_data [2];
  logic [1:0]  r_resp [2];
  int          r_lat  [2];
  bit          r_ok   [2];

  // Handshake counters, used to catch duplicated or missing responses.
  always @(posedge aclk) begin
    for (int d = 0; d < 2; d++) begin
      if (bvalid_s[d] && bready) b_cnt[d] <= b_cnt[d] + 1;
      if (rvalid_s[d] && rready) r_cnt[d] <= r_cnt[d] + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic bit in_range_m(input logic [31:0] a);
    return a < 32'(DEPTH * 4);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    return in_range_m(a) ? mem_m[a[5:2]] : 32'h0;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] data, input logic [3:0] strb);
    if (in_range_m(a))
      for (int b = 0; b < 4; b++)
        if (strb[b]) mem_m[a[5:2]][b*8 +: 8] = data[b*8 +: 8];
  endtask

  // lead > 0: W presented lead cycles before AW; lead < 0: AW first.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int lead, input bit hold_b);
    int aw_at, w_at;
    bit aw_ok, w_ok;
    bit got [2];
    aw_at = (lead > 0) ? lead : 0;
    w_at  = (lead < 0) ? -lead : 0;
    aw_ok = 1'b0; w_ok = 1'b0;
    for (int d = 0; d < 2; d++) begin got[d] = 1'b0; b_lat[d] = -1; b_resp[d] = 2'bxx; end
    awaddr = addr; wdata = data; wstrb = strb; bready = !hold_b;
    for (int c = 0; c < 64 && !(aw_ok && w_ok); c++) begin
      @(negedge aclk);
      awvalid = !aw_ok && (c >= aw_at);
      wvalid  = !w_ok && (c >= w_at);
      if (awvalid && awready_s[0] && awready_s[1]) aw_ok = 1'b1;
      if (wvalid && wready_s[0] && wready_s[1]) w_ok = 1'b1;
    end
    check("wr_accepted", 32'(aw_ok && w_ok), 32'd1);
    for (int k = 1; k <= 40 && !(got[0] && got[1]); k++) begin
      @(negedge aclk);
      awvalid = 1'b0; wvalid = 1'b0;
      for (int d = 0; d < 2; d++)
        if (!got[d] && bvalid_s[d]) begin
          got[d] = 1'b1; b_lat[d] = k; b_resp[d] = bresp_s[d];
        end
    end
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  // r_ok: data/resp stable while held, arready low while pending, high right after.
  task automatic do_read(input logic [31:0] addr, input int rlow);
    bit ar_ok;
    int st [2];
    araddr = addr; rready = 1'b0; ar_ok = 1'b0;
    for (int d = 0; d < 2; d++) begin st[d] = 0; r_lat[d] = -1; r_ok[d] = 1'b1; r_data[d] = 'x; r_resp[d] = 'x; end
    for (int c = 0; c < 64 && !ar_ok; c++) begin
      @(negedge aclk);
      arvalid = 1'b1;
      if (arready_s[0] && arready_s[1]) ar_ok = 1'b1;
    end
    check("rd_accepted", 32'(ar_ok), 32'd1);
    for (int k = 1; k <= 60 && !(st[0] == 2 && st[1] == 2); k++) begin
      @(negedge aclk);
      arvalid = 1'b0;
      rready  = (k > rlow);
      for (int d = 0; d < 2; d++) begin
        if (st[d] == 1) begin
          if (!arready_s[d]) r_ok[d] = 1'b0;
          st[d] = 2;
        end else if (st[d] == 0) begin
          if (arready_s[d]) r_ok[d] = 1'b0;
          if (rvalid_s[d]) begin
            if (r_lat[d] < 0) begin
              r_lat[d] = k; r_data[d] = rdata_s[d]; r_resp[d] = rresp_s[d];
            end else if (rdata_s[d] !== r_data[d] || rresp_s[d] !== r_resp[d]) begin
              r_ok[d] = 1'b0;
            end
            if (rready) st[d] = 1;
          end
        end
      end
    end
    arvalid = 1'b0;
    rready  = 1'b1;
  endtask

  task automatic write_chk(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int lead);
    logic [1:0] exp_resp;
    exp_resp = in_range_m(addr) ? 2'b00 : 2'b10;
    do_write(addr, data, strb, lead, 1'b0);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("bresp_d%0d", d), 32'(b_resp[d]), 32'(exp_resp));
      check($sformatf("blat_d%0d", d), 32'(b_lat[d]), 32'(1 + wait_of(d)));
    end
    model_write(addr, data, strb);
    n_wr++;
  endtask

  task automatic read_chk(input logic [31:0] addr, input int rlow);
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    exp_data = model_read(addr);
    exp_resp = in_range_m(addr) ? 2'b00 : 2'b10;
    do_read(addr, rlow);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rdata_d%0d@%0h", d, addr), r_data[d], exp_data);
      check($sformatf("rresp_d%0d", d), 32'(r_resp[d]), 32'(exp_resp));
      check($sformatf("rlat_d%0d", d), 32'(r_lat[d]), 32'(1 + wait_of(d)));
      check($sformatf("rhold_d%0d", d), 32'(r_ok[d]), 32'd1);
    end
    n_rd++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, dat;
    logic [31:0] old_word;
    areset_n = 1'b0;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;

    repeat (3) @(negedge aclk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_ctrl_d%0d", d),
            32'({awready_s[d], wready_s[d], arready_s[d], bvalid_s[d], rvalid_s[d]}), 32'd0);
      check($sformatf("rst_resp_d%0d", d), 32'({bresp_s[d], rresp_s[d]}), 32'd0);
      check($sformatf("rst_rdata_d%0d", d), rdata_s[d], 32'd0);
    end
    areset_n = 1'b1;
    @(negedge aclk);
    for (int d = 0; d < 2; d++)
      check($sformatf("ready_after_rst_d%0d", d),
            32'({awready_s[d], wready_s[d], arready_s[d]}), 32'b111);

    // Basic write/read, then a partial-strobe merge.
    write_chk(32'h4, 32'hDEADBEEF, 4'hF, 0);
    read_chk(32'h4, 0);
    write_chk(32'h8, 32'h11223344, 4'hF, 0);
    write_chk(32'h8, 32'hAABBCCDD, 4'h5, 0);
    read_chk(32'h8, 0);
    check("partial_strobe", r_data[0], 32'h11BB33DD);
    write_chk(32'h8, 32'hFFFFFFFF, 4'h0, 0);
    read_chk(32'h8, 0);

    // Channel ordering in both directions.
    write_chk(32'hC, 32'hCAFEF00D, 4'hF, 3);
    read_chk(32'hC, 0);
    write_chk(32'h10, 32'h0BADC0DE, 4'hF, -3);
    read_chk(32'h10, 0);

    // Out of range: discarded, SLVERR, and no aliasing onto word 0.
    write_chk(32'h0, 32'h01020304, 4'hF, 0);
    write_chk(32'h40, 32'h99999999, 4'hF, 0);
    read_chk(32'h40, 0);
    read_chk(32'h0, 0);
    write_chk(32'hFFFF_FFF0, 32'h77777777, 4'hF, 1);
    read_chk(32'hFFFF_FFF0, 2);

    // Response backpressure with rready held low for five cycles.
    read_chk(32'h4, 5);

    // Same-edge write commit and read sample: only the WAIT 0 read sees the old word.
    write_chk(32'h14, 32'h11111111, 4'hF, 0);
    old_word = model_read(32'h14);
    fork
      do_write(32'h14, 32'h22222222, 4'hF, 0, 1'b0);
      do_read(32'h14, 0);
    join
    model_write(32'h14, 32'h22222222, 4'hF);
    n_wr++; n_rd++;
    check("collide_bresp_d0", 32'(b_resp[0]), 32'd0);
    check("collide_old_d0", r_data[0], old_word);
    check("collide_new_d1", r_data[1], model_read(32'h14));

    // Randomized traffic, including low address bits and out-of-range words.
    for (int n = 0; n < 40; n++) begin
      a = 32'($urandom_range(0, 19)) * 4 + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        dat = $urandom;
        write_chk(a, dat, 4'($urandom_range(0, 15)), int'($urandom_range(0, 6)) - 3);
      end else begin
        read_chk(a, int'($urandom_range(0, 3)));
      end
    end

    @(negedge aclk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("b_count_d%0d", d), 32'(b_cnt[d]), 32'(n_wr));
      check($sformatf("r_count_d%0d", d), 32'(r_cnt[d]), 32'(n_rd));
    end

    // Reset while both write responses are pending.
    do_write(32'h18, 32'h5A5A5A5A, 4'hF, 0, 1'b1);
    for (int d = 0; d < 2; d++)
      check($sformatf("b_pending_d%0d", d), 32'(bvalid_s[d]), 32'd1);
    #2 areset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++)
      check($sformatf("b_drop_on_rst_d%0d", d), 32'(bvalid_s[d]), 32'd0);
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    bready = 1'b1;
    repeat (2) @(negedge aclk);
    areset_n = 1'b1;
    read_chk(32'h4, 0);
    read_chk(32'h18, 1);
    write_chk(32'h1C, 32'h13572468, 4'hF, 0);
    read_chk(32'h1C, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_mem_slave.md
Name: axi_lite_mem_slave

Overview:
- AXI4-Lite responder (slave) with an internal word-addressed register memory, byte-strobe writes, programmable wait states and SLVERR for out-of-range accesses.
- Sits at the slave end of the axi_lite_if bus, opposite axi_lite_master.
- Serves as a checkable memory target for master-side traffic and error-path coverage.
- Read and write channels are fully independent.

Parameters:
- ADDR_WIDTH, 32, address bus width
- DATA_WIDTH, 32, data bus width; fixed at 32 for this revision
- MEM_DEPTH, 16, number of 32-bit words
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned
- WAIT_CYCLES, 0, extra cycles inserted before each BVALID/RVALID (0..15)

Ports:
- aclk  in  1  clock, all logic on rising edge
- areset_n  in  1  asynchronous active-low reset
- awaddr  in  ADDR_WIDTH  write address
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- wdata  in  32  write data
- wstrb  in  4  byte strobes
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- bresp  out  2  write response
- bvalid  out  1  write response valid
- bready  in  1  write response ready
- araddr  in  ADDR_WIDTH  read address
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rdata  out  32  read data
- rresp  out  2  read response
- rvalid  out  1  read data valid
- rready  in  1  read data ready

Behaviour:
Reset (async assert, sync release):
- awready, wready, arready, bvalid, rvalid = 0; bresp, rresp = 2'b00; rdata = 0; all memory words = 0.
- Readies rise on the first clock edge after release.
- Reset asserted mid-transaction aborts it; no response is issued afterwards.

Address decode:
- idx = (addr - BASE_ADDR) >> 2; addr[1:0] ignored.
- In range iff addr >= BASE_ADDR and idx < MEM_DEPTH; otherwise resp = 2'b10 (SLVERR).
- OKAY = 2'b00. No other response codes are generated.

Write FSM (W_IDLE -> W_WAIT -> W_RESP):
- W_IDLE: awready = 1 until the AW handshake, wready = 1 until the W handshake; each channel is captured independently, in either order or in the same cycle.
- Once AW is captured, awready drops and stays low until the B handshake; same rule for W and wready.
- When both are captured: commit to memory at that edge; bytes with wstrb[i] = 0 keep their old value; wstrb = 0 writes nothing but still returns OKAY. An out-of-range write is discarded and returns SLVERR.
- Then count WAIT_CYCLES in W_WAIT (skipped when 0), then go to W_RESP.
- W_RESP: bvalid = 1 with bresp stable until bready; on the B handshake return to W_IDLE with awready = wready = 1 the next cycle.
- Latency: with both handshakes at edge N, bvalid is high from N+1+WAIT_CYCLES.

Read FSM (R_IDLE -> R_WAIT -> R_DATA):
- R_IDLE: arready = 1; on the AR handshake capture the address and drop arready.
- After WAIT_CYCLES, sample memory into rdata (0 if out of range) and assert rvalid with rresp.
- rdata and rresp are held until rready; after the R handshake, arready = 1 the next cycle.
- Latency: AR at edge N gives rvalid from N+1+WAIT_CYCLES.

Simultaneous events:
- A write commit and a read sample of the same word in the same cycle: the read returns the pre-write value.
- Read and write channels never stall each other.

Backpressure:
- bready or rready held low keeps the response valid indefinitely; no new address is accepted on that channel meanwhile.

Test Plan:
- Reset, WAIT_CYCLES = 0: write 0xDEADBEEF to 0x4 with wstrb = 0xF, AW and W in the same cycle -> bvalid the next cycle, bresp = 00; read 0x4 -> rvalid the cycle after AR, rdata = 0xDEADBEEF, rresp = 00.
- Partial strobe: word 0x8 holds 0x11223344; write 0xAABBCCDD with wstrb = 0x5 -> read 0x8 returns 0x11BB33DD.
- Channel ordering: W presented 3 cycles before AW, then the reverse -> a single commit each time, one B response each, correct data read back.
- Out of range, MEM_DEPTH = 16: write to 0x40 -> bresp = 10 and memory unchanged; read 0x40 -> rresp = 10, rdata = 0.
- WAIT_CYCLES = 3, rready held low for 5 cycles: AR at edge N -> rvalid from N+4, data stable until the handshake; arready stays low until one cycle after the handshake.
- Reset pulsed while bvalid is pending -> bvalid drops immediately, memory reads back 0, and the next write completes normally.
